axi_grid_vh_merge: RTL
======================

// Module: axi_grid_vh_merge
//
// PURPOSE
// - Merges the vertical and horizontal grid channels arriving at a grid node into one registered output.
// - Uses fair round-robin arbitration between the two inputs.
// - Sits downstream of the per-node V/H split stage. It feeds the node's local network-interface port
//   or its next-hop link.
// - Output is a single registered stage: 1-cycle latency, full throughput (1 beat/cycle).
//
// PARAMETERS
// - grid_id_t   default axi_default_param_pkg::grid_id_t   type of destination/source grid ID
// - chan_t      default axi_default_param_pkg::grid_id_t   type of the carried channel payload
// - V_FIRST     default 1   1: V input wins the first contention after reset; 0: H wins
//
// PORTS
// - clk_i       in   1               clock, all state on rising edge
// - rst_i       in   1               synchronous reset, active high
// - v_did_i     in   grid_id_t       vertical input destination ID
// - v_sid_i     in   grid_id_t       vertical input source ID
// - v_chan_i    in   chan_t          vertical input payload
// - v_valid_i   in   1               vertical input valid
// - v_ready_o   out  1               vertical input ready
// - h_did_i     in   grid_id_t       horizontal input destination ID
// - h_sid_i     in   grid_id_t       horizontal input source ID
// - h_chan_i    in   chan_t          horizontal input payload
// - h_valid_i   in   1               horizontal input valid
// - h_ready_o   out  1               horizontal input ready
// - did_o       out  grid_id_t       merged output destination ID
// - sid_o       out  grid_id_t       merged output source ID
// - chan_o      out  chan_t          merged output payload
// - valid_o     out  1               merged output valid
// - ready_i     in   1               merged output ready
//
// BEHAVIOUR
// - Clock and reset: one clock (clk_i). rst_i is synchronous and active high; it overrides all other
//   activity in that cycle.
// - Reset values:
//   - full_q=0, so valid_o=0.
//   - did_o/sid_o/chan_o='0.
//   - last_q (last granted input) = H if V_FIRST=1, else V.
// - Handshake: valid/ready. A beat transfers on a cycle where valid&ready=1.
//   - valid_o must not drop, and did_o/sid_o/chan_o must not change, while valid_o=1 and ready_i=0.
// - Register state: output register with full_q flag.
//   - can_load = ~full_q | ready_i. A pop and a load in the same cycle are allowed.
// - Arbitration (combinational, evaluated every cycle):
//   - only v_valid_i=1      -> grant V
//   - only h_valid_i=1      -> grant H
//   - both valid            -> grant the input that is NOT last_q
//   - neither valid         -> no grant
// - Ready outputs:
//   - v_ready_o = grant_v & can_load
//   - h_ready_o = grant_h & can_load
//   - At most one of v_ready_o/h_ready_o is 1 in any cycle.
//   - A ready may depend combinationally on the other input's valid.
//   - There is no path from ready_i to any input valid.
// - On a load (granted valid & can_load):
//   - did/sid/chan of the granted input are captured into the output register.
//   - full_q<=1; last_q<=granted input.
// - Pop without load (valid_o & ready_i & no grant): full_q<=0; data registers hold their value.
// - Hold (full_q & ~ready_i): all registers unchanged. Both input readys are 0.
// - last_q changes only on a load, never on a stall or an idle cycle.
// - Latency: a beat accepted in cycle N is presented on the output in cycle N+1.
// - Boundary: reset mid-stall clears valid_o on the next edge; the held beat is dropped.
//   Upstream must treat reset as a global flush.
// - Boundary: with both inputs continuously valid and ready_i=1, grants alternate V,H,V,H...
//   No input waits more than 1 beat.
//
// TESTING
// - Reset: assert rst_i 2 cycles with both valids=1 -> valid_o=0, v_ready_o=h_ready_o=0 during reset;
//   first cycle after reset V granted (V_FIRST=1).
// - Single source: only V valid, 4 beats with did=1..4, ready_i=1 -> output did=1..4 on consecutive
//   cycles, each 1 cycle after acceptance; h_ready_o=0 throughout.
// - Contention: both valid for 6 cycles, ready_i=1, V chan=A0..A2, H chan=B0..B2 -> output order
//   A0,B0,A1,B1,A2,B2.
// - Backpressure: output holding chan=0x5A, ready_i=0 for 3 cycles, both inputs valid -> chan_o stays
//   0x5A, v_ready_o=h_ready_o=0; last_q unchanged; on release, the input not last granted loads next.
// - Pop+load: full_q=1, ready_i=1, H valid chan=0x33 -> same cycle pop and load; next cycle
//   chan_o=0x33 with valid_o=1 and no bubble.
// - Reset mid-stall: full_q=1, ready_i=0, pulse rst_i 1 cycle -> valid_o=0 the next cycle; the next
//   contention grants V.

Source files
------------

// File: rtl/axi_grid_vh_merge.sv
// Two-input (vertical/horizontal) round-robin merge into one registered output stage.
// 1-cycle latency and 1 beat/cycle throughput. A pop and a load can happen in the same cycle.
package axi_default_param_pkg;
  typedef logic [7:0] grid_id_t;
endpackage

module axi_grid_vh_merge #(
  parameter type grid_id_t = axi_default_param_pkg::grid_id_t,
  parameter type chan_t    = axi_default_param_pkg::grid_id_t,
  parameter bit  V_FIRST   = 1'b1
) (
  input  logic     clk_i,
  input  logic     rst_i,
  input  grid_id_t v_did_i,
  input  grid_id_t v_sid_i,
  input  chan_t    v_chan_i,
  input  logic     v_valid_i,
  output logic     v_ready_o,
  input  grid_id_t h_did_i,
  input  grid_id_t h_sid_i,
  input  chan_t    h_chan_i,
  input  logic     h_valid_i,
  output logic     h_ready_o,
  output grid_id_t did_o,
  output grid_id_t sid_o,
  output chan_t    chan_o,
  output logic     valid_o,
  input  logic     ready_i
);

  typedef enum logic {SRC_V = 1'b0, SRC_H = 1'b1} src_e;

  // Reset last_q to the loser so that the preferred input wins the first contention.
  localparam src_e LAST_RST = V_FIRST ? SRC_H : SRC_V;

  logic     full_q, full_d;
  grid_id_t did_q, did_d;
  grid_id_t sid_q, sid_d;
  chan_t    chan_q, chan_d;
  src_e     last_q, last_d;

  logic grant_v, grant_h, can_load, load;

  always_comb begin
    grant_v  = v_valid_i & (~h_valid_i | (last_q == SRC_H));
    grant_h  = h_valid_i & (~v_valid_i | (last_q == SRC_V));
    can_load = ~full_q | ready_i;
    load     = (grant_v | grant_h) & can_load;

    full_d = full_q;
    did_d  = did_q;
    sid_d  = sid_q;
    chan_d = chan_q;
    last_d = last_q;
    if (load) begin
      full_d = 1'b1;
      if (grant_v) begin
        did_d  = v_did_i;
        sid_d  = v_sid_i;
        chan_d = v_chan_i;
        last_d = SRC_V;
      end else begin
        did_d  = h_did_i;
        sid_d  = h_sid_i;
        chan_d = h_chan_i;
        last_d = SRC_H;
      end
    end else if (ready_i) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      full_q <= 1'b0;
      did_q  <= '0;
      sid_q  <= '0;
      chan_q <= '0;
      last_q <= LAST_RST;
    end else begin
      full_q <= full_d;
      did_q  <= did_d;
      sid_q  <= sid_d;
      chan_q <= chan_d;
      last_q <= last_d;
    end
  end

  // Readys are masked during reset so that no upstream beat is consumed while it is flushed.
  assign v_ready_o = grant_v & can_load & ~rst_i;
  assign h_ready_o = grant_h & can_load & ~rst_i;

  assign valid_o = full_q;
  assign did_o   = did_q;
  assign sid_o   = sid_q;
  assign chan_o  = chan_q;

endmodule
